// File: rtl/tx_char_replacer.sv
// rtl/tx_char_replacer.sv - JESD204B TX alignment-character replacer; optional insertion counters via CHAR_REPL_STATS_EN
module tx_char_replacer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_F,
    input  logic [4:0] i_K,
    input  logic       i_scr_en,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_vld,
    output logic [7:0] o_data,
    output logic       o_k,
    output logic       o_vld,
    output logic       o_eof,
    output logic       o_eomf
`ifdef CHAR_REPL_STATS_EN
    ,
    output logic [15:0] o_a_cnt,
    output logic [15:0] o_f_cnt
`endif
);

    localparam logic [7:0] CHAR_A = 8'h7C;
    localparam logic [7:0] CHAR_F = 8'hFC;

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] cfg_f_q, cfg_f_d;
    logic [4:0] cfg_k_q, cfg_k_d;
    logic       cfg_scr_q, cfg_scr_d;
    logic [7:0] octet_cnt_q, octet_cnt_d;
    logic [4:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] prev_q, prev_d;
    logic       prev_ok_q, prev_ok_d;
    logic [7:0] data_q, data_d;
    logic       k_q, k_d;
    logic       vld_q, vld_d;
    logic       eof_q, eof_d;
    logic       eomf_q, eomf_d;

    // Position/history as seen by the current octet (i_start realigns same cycle)
    logic [7:0] octet_cur;
    logic [4:0] frame_cur;
    logic       prev_ok_cur;
    logic       eof_c, eomf_c;
    logic       repl_a, repl_f;

    // Next-state: realignment, position tracking, replacement and output staging
    always_comb begin
        state_d     = state_q;
        cfg_f_d     = cfg_f_q;
        cfg_k_d     = cfg_k_q;
        cfg_scr_d   = cfg_scr_q;
        prev_d      = prev_q;
        data_d      = data_q;
        k_d         = k_q;
        vld_d       = i_vld;
        eof_d       = 1'b0;
        eomf_d      = 1'b0;
        repl_a      = 1'b0;
        repl_f      = 1'b0;
        octet_cur   = octet_cnt_q;
        frame_cur   = frame_cnt_q;
        prev_ok_cur = prev_ok_q;

        if (i_start) begin
            state_d     = RUN;
            cfg_f_d     = i_F;
            cfg_k_d     = i_K;
            cfg_scr_d   = i_scr_en;
            octet_cur   = 8'd0;
            frame_cur   = 5'd0;
            prev_ok_cur = 1'b0;
        end

        octet_cnt_d = octet_cur;
        frame_cnt_d = frame_cur;
        prev_ok_d   = prev_ok_cur;

        eof_c  = (state_d == RUN) && (octet_cur == cfg_f_d);
        eomf_c = eof_c && (frame_cur == cfg_k_d);

        if (i_vld && eof_c && !i_k) begin
            if (cfg_scr_d) begin
                repl_a = eomf_c && (i_data == CHAR_A);
                repl_f = !eomf_c && (i_data == CHAR_F);
            end else if (prev_ok_cur && (i_data == prev_q)) begin
                repl_a = eomf_c;
                repl_f = !eomf_c;
            end
        end

        if (i_vld) begin
            data_d = repl_a ? CHAR_A : (repl_f ? CHAR_F : i_data);
            k_d    = repl_a || repl_f || i_k;
            eof_d  = eof_c;
            eomf_d = eomf_c;
            if (state_d == RUN) begin
                if (eof_c) begin
                    octet_cnt_d = 8'd0;
                    frame_cnt_d = (frame_cur == cfg_k_d) ? 5'd0 : frame_cur + 5'd1;
                    prev_d      = i_data;
                    prev_ok_d   = !(repl_a || repl_f) && !i_k;
                end else begin
                    octet_cnt_d = octet_cur + 8'd1;
                end
            end
        end
    end

    // State, configuration and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_f_q     <= 8'd0;
            cfg_k_q     <= 5'd0;
            cfg_scr_q   <= 1'b0;
            octet_cnt_q <= 8'd0;
            frame_cnt_q <= 5'd0;
            prev_q      <= 8'd0;
            prev_ok_q   <= 1'b0;
            data_q      <= 8'hBC;
            k_q         <= 1'b1;
            vld_q       <= 1'b0;
            eof_q       <= 1'b0;
            eomf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_f_q     <= cfg_f_d;
            cfg_k_q     <= cfg_k_d;
            cfg_scr_q   <= cfg_scr_d;
            octet_cnt_q <= octet_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            data_q      <= data_d;
            k_q         <= k_d;
            vld_q       <= vld_d;
            eof_q       <= eof_d;
            eomf_q      <= eomf_d;
        end
    end

    assign o_data = data_q;
    assign o_k    = k_q;
    assign o_vld  = vld_q;
    assign o_eof  = eof_q;
    assign o_eomf = eomf_q;

`ifdef CHAR_REPL_STATS_EN
    logic [15:0] a_cnt_q, a_cnt_d;
    logic [15:0] f_cnt_q, f_cnt_d;
    logic [15:0] a_base, f_base;

    // Saturating insertion counters; i_start clears before counting its own octet
    always_comb begin
        a_base  = i_start ? 16'd0 : a_cnt_q;
        f_base  = i_start ? 16'd0 : f_cnt_q;
        a_cnt_d = (repl_a && (a_base != 16'hFFFF)) ? a_base + 16'd1 : a_base;
        f_cnt_d = (repl_f && (f_base != 16'hFFFF)) ? f_base + 16'd1 : f_base;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt_q <= 16'd0;
            f_cnt_q <= 16'd0;
        end else begin
            a_cnt_q <= a_cnt_d;
            f_cnt_q <= f_cnt_d;
        end
    end

    assign o_a_cnt = a_cnt_q;
    assign o_f_cnt = f_cnt_q;
`endif

endmodule
